// File: rtl/superbank_pkg.sv
// Shared types for the superbank arbiter: requester identity and
// per-superbank priority state.
package superbank_pkg;

    typedef enum logic {
        SRC_DMA  = 1'b0,
        SRC_CORE = 1'b1
    } arb_src_e;

    typedef enum logic {
        DMA_PRIO  = 1'b0,
        CORE_PRIO = 1'b1
    } arb_state_e;

endpackage

// File: rtl/superbank_arb_slice.sv
// One superbank: DMA/core priority FSM with a core starvation counter, and
// a response tracker that routes read data back to whoever issued it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DMA_PRIO  | DMA wins on conflict; count cycles the core is left waiting
// CORE_PRIO | core wins until it completes a handshake or drops its request
module superbank_arb_slice
    import superbank_pkg::*;
#(
    parameter int unsigned TCDMAddrWidth = 10,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AmoWidth      = 4,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned MaxDmaStall   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dma_req_i,
    output logic                     dma_gnt_o,
    input  logic [TCDMAddrWidth-1:0] dma_add_i,
    input  logic [AmoWidth-1:0]      dma_amo_i,
    input  logic                     dma_wen_i,
    input  logic [DataWidth-1:0]     dma_wdata_i,
    input  logic [DataWidth/8-1:0]   dma_be_i,
    output logic [DataWidth-1:0]     dma_rdata_o,
    output logic                     dma_rvalid_o,
    input  logic                     core_req_i,
    output logic                     core_gnt_o,
    input  logic [TCDMAddrWidth-1:0] core_add_i,
    input  logic [AmoWidth-1:0]      core_amo_i,
    input  logic                     core_wen_i,
    input  logic [DataWidth-1:0]     core_wdata_i,
    input  logic [DataWidth/8-1:0]   core_be_i,
    output logic [DataWidth-1:0]     core_rdata_o,
    output logic                     core_rvalid_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [TCDMAddrWidth-1:0] mem_add_o,
    output logic [AmoWidth-1:0]      mem_amo_o,
    output logic                     mem_wen_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    input  logic [DataWidth-1:0]     mem_rdata_i
);

    localparam int unsigned StallWidth = $clog2(MaxDmaStall + 1);

    arb_state_e            state_q, state_d;
    logic [StallWidth-1:0] stall_q, stall_d;
    arb_src_e              sel_src;
    logic                  any_req;
    logic                  core_stall;

    logic     [MemoryLatency-1:0] trk_vld_q;
    arb_src_e                     trk_src_q [MemoryLatency];

    // Pick the requester for this cycle and hand it the memory grant.
    always_comb begin
        sel_src = SRC_DMA;
        if (state_q == CORE_PRIO) begin
            if (core_req_i) sel_src = SRC_CORE;
        end else if (!dma_req_i && core_req_i) begin
            sel_src = SRC_CORE;
        end
        any_req    = dma_req_i | core_req_i;
        dma_gnt_o  = any_req && (sel_src == SRC_DMA)  && mem_gnt_i;
        core_gnt_o = any_req && (sel_src == SRC_CORE) && mem_gnt_i;
        core_stall = core_req_i && !core_gnt_o;
    end

    // Priority hand-over: the core takes over once it has waited MaxDmaStall cycles.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        unique case (state_q)
            DMA_PRIO: begin
                if (core_stall) begin
                    if (stall_q != StallWidth'(MaxDmaStall)) stall_d = stall_q + StallWidth'(1);
                    if (stall_q == StallWidth'(MaxDmaStall - 1)) state_d = CORE_PRIO;
                end else begin
                    stall_d = '0;
                end
            end
            CORE_PRIO: begin
                if (!core_stall || !core_req_i) begin
                    state_d = DMA_PRIO;
                    stall_d = '0;
                end
            end
            default: begin
                state_d = DMA_PRIO;
                stall_d = '0;
            end
        endcase
    end

    // Drive the selected payload to memory; idle bus is all-zero.
    always_comb begin
        mem_req_o   = any_req;
        mem_add_o   = '0;
        mem_amo_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (any_req) begin
            if (sel_src == SRC_CORE) begin
                mem_add_o   = core_add_i;
                mem_amo_o   = core_amo_i;
                mem_wen_o   = core_wen_i;
                mem_wdata_o = core_wdata_i;
                mem_be_o    = core_be_i;
            end else begin
                mem_add_o   = dma_add_i;
                mem_amo_o   = dma_amo_i;
                mem_wen_o   = dma_wen_i;
                mem_wdata_o = dma_wdata_i;
                mem_be_o    = dma_be_i;
            end
        end
    end

    // Priority state and starvation counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DMA_PRIO;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Track every handshake for MemoryLatency cycles so its data returns to the issuer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk_vld_q <= '0;
            for (int i = 0; i < int'(MemoryLatency); i++) trk_src_q[i] <= SRC_DMA;
        end else begin
            trk_vld_q[0] <= any_req & mem_gnt_i;
            trk_src_q[0] <= sel_src;
            for (int i = 1; i < int'(MemoryLatency); i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_src_q[i] <= trk_src_q[i-1];
            end
        end
    end

    assign dma_rvalid_o  = trk_vld_q[MemoryLatency-1] && (trk_src_q[MemoryLatency-1] == SRC_DMA);
    assign core_rvalid_o = trk_vld_q[MemoryLatency-1] && (trk_src_q[MemoryLatency-1] == SRC_CORE);
    assign dma_rdata_o   = dma_rvalid_o  ? mem_rdata_i : '0;
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/superbank_arbiter.sv
// DMA/core arbiter in front of NrSuperBanks independent superbanks.
module superbank_arbiter
    import superbank_pkg::*;
#(
    parameter int unsigned NrSuperBanks  = 4,
    parameter int unsigned TCDMAddrWidth = 10,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AmoWidth      = 4,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned MaxDmaStall   = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NrSuperBanks-1:0]                     dma_req_i,
    output logic [NrSuperBanks-1:0]                     dma_gnt_o,
    input  logic [NrSuperBanks-1:0][TCDMAddrWidth-1:0]  dma_add_i,
    input  logic [NrSuperBanks-1:0][AmoWidth-1:0]       dma_amo_i,
    input  logic [NrSuperBanks-1:0]                     dma_wen_i,
    input  logic [NrSuperBanks-1:0][DataWidth-1:0]      dma_wdata_i,
    input  logic [NrSuperBanks-1:0][DataWidth/8-1:0]    dma_be_i,
    output logic [NrSuperBanks-1:0][DataWidth-1:0]      dma_rdata_o,
    output logic [NrSuperBanks-1:0]                     dma_rvalid_o,
    input  logic [NrSuperBanks-1:0]                     core_req_i,
    output logic [NrSuperBanks-1:0]                     core_gnt_o,
    input  logic [NrSuperBanks-1:0][TCDMAddrWidth-1:0]  core_add_i,
    input  logic [NrSuperBanks-1:0][AmoWidth-1:0]       core_amo_i,
    input  logic [NrSuperBanks-1:0]                     core_wen_i,
    input  logic [NrSuperBanks-1:0][DataWidth-1:0]      core_wdata_i,
    input  logic [NrSuperBanks-1:0][DataWidth/8-1:0]    core_be_i,
    output logic [NrSuperBanks-1:0][DataWidth-1:0]      core_rdata_o,
    output logic [NrSuperBanks-1:0]                     core_rvalid_o,
    output logic [NrSuperBanks-1:0]                     mem_req_o,
    input  logic [NrSuperBanks-1:0]                     mem_gnt_i,
    output logic [NrSuperBanks-1:0][TCDMAddrWidth-1:0]  mem_add_o,
    output logic [NrSuperBanks-1:0][AmoWidth-1:0]       mem_amo_o,
    output logic [NrSuperBanks-1:0]                     mem_wen_o,
    output logic [NrSuperBanks-1:0][DataWidth-1:0]      mem_wdata_o,
    output logic [NrSuperBanks-1:0][DataWidth/8-1:0]    mem_be_o,
    input  logic [NrSuperBanks-1:0][DataWidth-1:0]      mem_rdata_i
);

    for (genvar s = 0; s < NrSuperBanks; s++) begin : g_slice
        superbank_arb_slice #(
            .TCDMAddrWidth (TCDMAddrWidth),
            .DataWidth     (DataWidth),
            .AmoWidth      (AmoWidth),
            .MemoryLatency (MemoryLatency),
            .MaxDmaStall   (MaxDmaStall)
        ) i_slice (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .dma_req_i     (dma_req_i[s]),
            .dma_gnt_o     (dma_gnt_o[s]),
            .dma_add_i     (dma_add_i[s]),
            .dma_amo_i     (dma_amo_i[s]),
            .dma_wen_i     (dma_wen_i[s]),
            .dma_wdata_i   (dma_wdata_i[s]),
            .dma_be_i      (dma_be_i[s]),
            .dma_rdata_o   (dma_rdata_o[s]),
            .dma_rvalid_o  (dma_rvalid_o[s]),
            .core_req_i    (core_req_i[s]),
            .core_gnt_o    (core_gnt_o[s]),
            .core_add_i    (core_add_i[s]),
            .core_amo_i    (core_amo_i[s]),
            .core_wen_i    (core_wen_i[s]),
            .core_wdata_i  (core_wdata_i[s]),
            .core_be_i     (core_be_i[s]),
            .core_rdata_o  (core_rdata_o[s]),
            .core_rvalid_o (core_rvalid_o[s]),
            .mem_req_o     (mem_req_o[s]),
            .mem_gnt_i     (mem_gnt_i[s]),
            .mem_add_o     (mem_add_o[s]),
            .mem_amo_o     (mem_amo_o[s]),
            .mem_wen_o     (mem_wen_o[s]),
            .mem_wdata_o   (mem_wdata_o[s]),
            .mem_be_o      (mem_be_o[s]),
            .mem_rdata_i   (mem_rdata_i[s])
        );
    end

endmodule

// File: tb/tb_superbank_arbiter.sv
// Bench for superbank_arbiter: a latency-1 and a latency-3 instance share all
// inputs; a rule-level model checks both every cycle, and directed scenarios
// pin hand-computed grant/response sequences.
module tb_superbank_arbiter;

    localparam int NB       = 4;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int MW       = 4;
    localparam int BW       = DW / 8;
    localparam int MaxStall = 4;
    localparam int HistLen  = 4096;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    logic [NB-1:0]         dma_req_i = '0, core_req_i = '0, mem_gnt_i = '0;
    logic [NB-1:0]         dma_wen_i = '0, core_wen_i = '0;
    logic [NB-1:0][AW-1:0] dma_add_i = '0, core_add_i = '0;
    logic [NB-1:0][MW-1:0] dma_amo_i = '0, core_amo_i = '0;
    logic [NB-1:0][DW-1:0] dma_wdata_i = '0, core_wdata_i = '0, mem_rdata_i = '0;
    logic [NB-1:0][BW-1:0] dma_be_i = '0, core_be_i = '0;

    logic [NB-1:0]         a_dma_gnt, a_dma_rvalid, a_core_gnt, a_core_rvalid, a_mem_req, a_mem_wen;
    logic [NB-1:0][DW-1:0] a_dma_rdata, a_core_rdata, a_mem_wdata;
    logic [NB-1:0][AW-1:0] a_mem_add;
    logic [NB-1:0][MW-1:0] a_mem_amo;
    logic [NB-1:0][BW-1:0] a_mem_be;

    logic [NB-1:0]         b_dma_gnt, b_dma_rvalid, b_core_gnt, b_core_rvalid, b_mem_req, b_mem_wen;
    logic [NB-1:0][DW-1:0] b_dma_rdata, b_core_rdata, b_mem_wdata;
    logic [NB-1:0][AW-1:0] b_mem_add;
    logic [NB-1:0][MW-1:0] b_mem_amo;
    logic [NB-1:0][BW-1:0] b_mem_be;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    superbank_arbiter #(.NrSuperBanks(NB), .TCDMAddrWidth(AW), .DataWidth(DW), .AmoWidth(MW),
                        .MemoryLatency(1), .MaxDmaStall(MaxStall)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .dma_req_i(dma_req_i), .dma_gnt_o(a_dma_gnt), .dma_add_i(dma_add_i), .dma_amo_i(dma_amo_i),
        .dma_wen_i(dma_wen_i), .dma_wdata_i(dma_wdata_i), .dma_be_i(dma_be_i),
        .dma_rdata_o(a_dma_rdata), .dma_rvalid_o(a_dma_rvalid),
        .core_req_i(core_req_i), .core_gnt_o(a_core_gnt), .core_add_i(core_add_i), .core_amo_i(core_amo_i),
        .core_wen_i(core_wen_i), .core_wdata_i(core_wdata_i), .core_be_i(core_be_i),
        .core_rdata_o(a_core_rdata), .core_rvalid_o(a_core_rvalid),
        .mem_req_o(a_mem_req), .mem_gnt_i(mem_gnt_i), .mem_add_o(a_mem_add), .mem_amo_o(a_mem_amo),
        .mem_wen_o(a_mem_wen), .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(mem_rdata_i)
    );

    superbank_arbiter #(.NrSuperBanks(NB), .TCDMAddrWidth(AW), .DataWidth(DW), .AmoWidth(MW),
                        .MemoryLatency(3), .MaxDmaStall(MaxStall)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .dma_req_i(dma_req_i), .dma_gnt_o(b_dma_gnt), .dma_add_i(dma_add_i), .dma_amo_i(dma_amo_i),
        .dma_wen_i(dma_wen_i), .dma_wdata_i(dma_wdata_i), .dma_be_i(dma_be_i),
        .dma_rdata_o(b_dma_rdata), .dma_rvalid_o(b_dma_rvalid),
        .core_req_i(core_req_i), .core_gnt_o(b_core_gnt), .core_add_i(core_add_i), .core_amo_i(core_amo_i),
        .core_wen_i(core_wen_i), .core_wdata_i(core_wdata_i), .core_be_i(core_be_i),
        .core_rdata_o(b_core_rdata), .core_rvalid_o(b_core_rvalid),
        .mem_req_o(b_mem_req), .mem_gnt_i(mem_gnt_i), .mem_add_o(b_mem_add), .mem_amo_o(b_mem_amo),
        .mem_wen_o(b_mem_wen), .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: whether the core currently owns priority, how long it has
    // been refused, and a per-cycle log of handshakes and their issuers.
    bit m_core_turn [NB];
    int m_run       [NB];
    bit hs_v        [NB][HistLen];
    bit hs_core     [NB][HistLen];
    int last_rst = -1;

    // A response is due now if a handshake happened exactly lat cycles ago
    // and no reset has been seen since then.
    function automatic bit resp_due(int s, int lat, bit want_core);
        int k;
        k = cyc - lat;
        if (rst_i || k < 0 || k <= last_rst) return 1'b0;
        return hs_v[s][k % HistLen] && (hs_core[s][k % HistLen] == want_core);
    endfunction

    logic        m_any, m_sel_core, m_gd, m_gc, m_rd1, m_rc1, m_rd3, m_rc3;
    logic [63:0] m_pay, a_pay, b_pay;

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk_i) begin
        for (int s = 0; s < NB; s++) begin
            if (rst_i) begin
                m_core_turn[s] = 1'b0;
                m_run[s]       = 0;
            end
            m_any      = dma_req_i[s] | core_req_i[s];
            m_sel_core = m_core_turn[s] ? core_req_i[s] : (core_req_i[s] & ~dma_req_i[s]);
            m_gd       = m_any & ~m_sel_core & mem_gnt_i[s];
            m_gc       = m_sel_core & mem_gnt_i[s];
            m_pay      = !m_any ? 64'd0 :
                         m_sel_core ? {core_add_i[s], core_amo_i[s], core_wen_i[s], core_wdata_i[s], core_be_i[s]}
                                    : {dma_add_i[s], dma_amo_i[s], dma_wen_i[s], dma_wdata_i[s], dma_be_i[s]};
            a_pay      = {a_mem_add[s], a_mem_amo[s], a_mem_wen[s], a_mem_wdata[s], a_mem_be[s]};
            b_pay      = {b_mem_add[s], b_mem_amo[s], b_mem_wen[s], b_mem_wdata[s], b_mem_be[s]};
            m_rd1      = resp_due(s, 1, 1'b0);
            m_rc1      = resp_due(s, 1, 1'b1);
            m_rd3      = resp_due(s, 3, 1'b0);
            m_rc3      = resp_due(s, 3, 1'b1);

            check($sformatf("a.dma_gnt[%0d]", s),     a_dma_gnt[s],     m_gd);
            check($sformatf("a.core_gnt[%0d]", s),    a_core_gnt[s],    m_gc);
            check($sformatf("a.mem_req[%0d]", s),     a_mem_req[s],     m_any);
            check($sformatf("a.mem_payload[%0d]", s), a_pay,            m_pay);
            check($sformatf("a.dma_rvalid[%0d]", s),  a_dma_rvalid[s],  m_rd1);
            check($sformatf("a.core_rvalid[%0d]", s), a_core_rvalid[s], m_rc1);
            check($sformatf("a.dma_rdata[%0d]", s),   a_dma_rdata[s],   m_rd1 ? mem_rdata_i[s] : '0);
            check($sformatf("a.core_rdata[%0d]", s),  a_core_rdata[s],  m_rc1 ? mem_rdata_i[s] : '0);
            check($sformatf("b.dma_gnt[%0d]", s),     b_dma_gnt[s],     m_gd);
            check($sformatf("b.core_gnt[%0d]", s),    b_core_gnt[s],    m_gc);
            check($sformatf("b.mem_payload[%0d]", s), b_pay,            m_pay);
            check($sformatf("b.dma_rvalid[%0d]", s),  b_dma_rvalid[s],  m_rd3);
            check($sformatf("b.core_rvalid[%0d]", s), b_core_rvalid[s], m_rc3);
            check($sformatf("b.dma_rdata[%0d]", s),   b_dma_rdata[s],   m_rd3 ? mem_rdata_i[s] : '0);
            check($sformatf("b.core_rdata[%0d]", s),  b_core_rdata[s],  m_rc3 ? mem_rdata_i[s] : '0);

            if (rst_i) begin
                last_rst = cyc;
                hs_v[s][cyc % HistLen] = 1'b0;
            end else begin
                hs_v[s][cyc % HistLen]    = m_any & mem_gnt_i[s];
                hs_core[s][cyc % HistLen] = m_sel_core;
                if (m_core_turn[s]) begin
                    if (!core_req_i[s] || m_gc) begin
                        m_core_turn[s] = 1'b0;
                        m_run[s]       = 0;
                    end
                end else if (core_req_i[s] && !m_gc) begin
                    m_run[s]++;
                    if (m_run[s] == MaxStall) m_core_turn[s] = 1'b1;
                end else begin
                    m_run[s] = 0;
                end
            end
        end
        cyc++;
    end

    // Advance one cycle, then apply idle requests with fresh random payloads.
    task automatic tick();
        @(posedge clk_i);
        #1;
        dma_req_i  = '0;
        core_req_i = '0;
        mem_gnt_i  = '0;
        for (int s = 0; s < NB; s++) begin
            dma_add_i[s]    = AW'($urandom);
            core_add_i[s]   = AW'($urandom);
            dma_amo_i[s]    = MW'($urandom);
            core_amo_i[s]   = MW'($urandom);
            dma_wen_i[s]    = 1'($urandom);
            core_wen_i[s]   = 1'($urandom);
            dma_wdata_i[s]  = $urandom;
            core_wdata_i[s] = $urandom;
            dma_be_i[s]     = BW'($urandom);
            core_be_i[s]    = BW'($urandom);
            mem_rdata_i[s]  = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: grants still follow inputs, no responses appear.
        tick();
        tick();
        dma_req_i[1] = 1'b1; core_req_i[1] = 1'b1; mem_gnt_i = '1;
        @(negedge clk_i);
        check("rst dma_gnt1", a_dma_gnt[1], 1);
        check("rst core_gnt1", a_core_gnt[1], 0);
        check("rst a.dma_rvalid", a_dma_rvalid, 0);
        check("rst b.core_rvalid", b_core_rvalid, 0);
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post-rst a.dma_rvalid", a_dma_rvalid, 0);
        check("post-rst a.core_rvalid", a_core_rvalid, 0);

        // Single DMA read on superbank 2.
        tick();
        dma_req_i[2] = 1'b1; dma_add_i[2] = 10'h03F; dma_wen_i[2] = 1'b0; mem_gnt_i = '1;
        @(negedge clk_i);
        check("t1 dma_gnt2", a_dma_gnt[2], 1);
        check("t1 mem_add2", a_mem_add[2], 10'h03F);
        check("t1 core_gnt2", a_core_gnt[2], 0);
        tick();
        @(negedge clk_i);
        check("t1 a.dma_rvalid2", a_dma_rvalid[2], 1);
        check("t1 a.dma_rdata2", a_dma_rdata[2], mem_rdata_i[2]);
        check("t1 b.dma_rvalid2 early", b_dma_rvalid[2], 0);
        tick();
        tick();
        @(negedge clk_i);
        check("t1 b.dma_rvalid2", b_dma_rvalid[2], 1);
        check("t1 b.core_rvalid2", b_core_rvalid[2], 0);
        check("t1 b.dma_rdata2", b_dma_rdata[2], mem_rdata_i[2]);
        check("t1 a.dma_rvalid2 once", a_dma_rvalid[2], 0);

        // Continuous contention on superbank 0: D D D D C D.
        for (int i = 0; i < 6; i++) begin
            tick();
            dma_req_i[0] = 1'b1; core_req_i[0] = 1'b1; mem_gnt_i[0] = 1'b1;
            @(negedge clk_i);
            check($sformatf("t2 dma_gnt0 c%0d", i + 1), a_dma_gnt[0], (i != 4));
            check($sformatf("t2 core_gnt0 c%0d", i + 1), a_core_gnt[0], (i == 4));
        end

        // Core priority held while memory refuses, on superbank 3.
        for (int i = 0; i < 9; i++) begin
            tick();
            dma_req_i[3] = 1'b1; core_req_i[3] = 1'b1;
            dma_add_i[3] = 10'h111; core_add_i[3] = 10'h222;
            mem_gnt_i[3] = (i >= 7);
            @(negedge clk_i);
            check($sformatf("t3 mem_add3 c%0d", i), a_mem_add[3], (i >= 4 && i <= 7) ? 10'h222 : 10'h111);
            check($sformatf("t3 core_gnt3 c%0d", i), a_core_gnt[3], (i == 7));
            check($sformatf("t3 dma_gnt3 c%0d", i), a_dma_gnt[3], (i == 8));
        end

        // Alternating DMA/core handshakes on superbank 1.
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 6) begin
                dma_req_i[1]  = (i % 2 == 0);
                core_req_i[1] = (i % 2 == 1);
                mem_gnt_i[1]  = 1'b1;
            end
            @(negedge clk_i);
            if (i > 0) begin
                check($sformatf("t4 dma_rvalid1 c%0d", i), a_dma_rvalid[1], ((i - 1) % 2 == 0));
                check($sformatf("t4 core_rvalid1 c%0d", i), a_core_rvalid[1], ((i - 1) % 2 == 1));
            end
        end

        // Reset right after a handshake, with superbank 3 in core priority
        // and superbank 0 partway through a stall count.
        for (int i = 0; i < 4; i++) begin
            tick();
            dma_req_i[3] = 1'b1; core_req_i[3] = 1'b1; mem_gnt_i[3] = 1'b0;
            if (i >= 2) begin
                dma_req_i[0] = 1'b1; core_req_i[0] = 1'b1; mem_gnt_i[0] = 1'b1;
            end
            if (i == 3) begin
                dma_req_i[2] = 1'b1; mem_gnt_i[2] = 1'b1;
            end
        end
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t5 a.dma_rvalid in rst", a_dma_rvalid, 0);
        check("t5 a.dma_rdata2 in rst", a_dma_rdata[2], 0);
        check("t5 b.dma_rvalid in rst", b_dma_rvalid, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            rst_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("t5 a.dma_rvalid after rst c%0d", j), a_dma_rvalid, 0);
            check($sformatf("t5 b.dma_rvalid after rst c%0d", j), b_dma_rvalid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            dma_req_i[0] = 1'b1; core_req_i[0] = 1'b1;
            dma_req_i[3] = 1'b1; core_req_i[3] = 1'b1;
            mem_gnt_i = '1;
            @(negedge clk_i);
            check($sformatf("t5 dma_gnt0 c%0d", i + 1), a_dma_gnt[0], (i != 4));
            check($sformatf("t5 core_gnt0 c%0d", i + 1), a_core_gnt[0], (i == 4));
            check($sformatf("t5 dma_gnt3 c%0d", i + 1), a_dma_gnt[3], (i != 4));
            check($sformatf("t5 core_gnt3 c%0d", i + 1), a_core_gnt[3], (i == 4));
        end

        for (int i = 0; i < 4; i++) tick();
        @(negedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/superbank_arbiter.md
SUPERBANK_ARBITER -- requirements
Module: superbank_arbiter

Interface
REQ-001 Parameter NrSuperBanks, default 4: number of superbanks arbitrated independently.
REQ-002 Parameter TCDMAddrWidth, default 10: superbank line address width.
REQ-003 Parameter DataWidth, default 512: superbank data width; byte enable is DataWidth/8.
REQ-004 Parameter AmoWidth, default 4: atomic operation code width.
REQ-005 Parameter MemoryLatency, default 1 (>=1): cycles from memory handshake to read data.
REQ-006 Parameter MaxDmaStall, default 8 (>=1): consecutive core-stall cycles before core gains priority.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clk_i  in  1  clock; all state on rising edge.
REQ-009 rst_i  in  1  asynchronous active-high reset.
REQ-010 dma_req_i / dma_gnt_o  in/out  [NrSuperBanks]  per-superbank DMA request / grant.
REQ-011 dma_add_i, dma_amo_i, dma_wen_i, dma_wdata_i, dma_be_i  in  [NrSuperBanks][field width]  DMA request payload.
REQ-012 dma_rdata_o / dma_rvalid_o  out  [NrSuperBanks][DataWidth] / [NrSuperBanks]  DMA read response.
REQ-013 core_req_i / core_gnt_o  in/out  [NrSuperBanks]  core-side aggregated request / grant.
REQ-014 core_add_i, core_amo_i, core_wen_i, core_wdata_i, core_be_i  in  [NrSuperBanks][field width]  core payload.
REQ-015 core_rdata_o / core_rvalid_o  out  [NrSuperBanks][DataWidth] / [NrSuperBanks]  core read response.
REQ-016 mem_req_o / mem_gnt_i  out/in  [NrSuperBanks]  superbank request / grant.
REQ-017 mem_add_o, mem_amo_o, mem_wen_o, mem_wdata_o, mem_be_o  out  [NrSuperBanks][field width]  selected payload.
REQ-018 mem_rdata_i  in  [NrSuperBanks][DataWidth]  superbank read data, valid MemoryLatency cycles after handshake.

Function (per superbank s, fully independent)
REQ-019 Two-state FSM: DMA_PRIO (reset) and CORE_PRIO.
REQ-020 DMA_PRIO: DMA selected if dma_req_i[s], else core if core_req_i[s].
REQ-021 CORE_PRIO: core selected if core_req_i[s], else DMA if dma_req_i[s].
REQ-022 mem_req_o[s] = dma_req_i[s] | core_req_i[s]; mem payload = selected requester's payload, all-zero when neither requests.
REQ-023 Grant combinational: selected requester's gnt = mem_gnt_i[s]; unselected gnt = 0; never both high.
REQ-024 Stall counter (width $clog2(MaxDmaStall+1)) increments each cycle core_req_i[s] & !core_gnt_o[s] in DMA_PRIO; clears on core handshake or core_req_i[s] low; saturates.
REQ-025 DMA_PRIO -> CORE_PRIO when counter equals MaxDmaStall-1 and core still stalled that cycle.
REQ-026 CORE_PRIO -> DMA_PRIO on core handshake or core_req_i[s] low; counter cleared.
REQ-027 Response tracker: MemoryLatency-deep shift register of {valid, src}; stage 0 loads {mem_req_o[s]&mem_gnt_i[s], selected src}.
REQ-028 xx_rvalid_o[s] = last stage valid & src match; xx_rdata_o[s] = mem_rdata_i[s] when matching rvalid, else 0.
REQ-029 Back-to-back handshakes every cycle supported; each response returned exactly once, in order.
REQ-030 Tracker advances regardless of new requests; no backpressure on responses.

Reset
REQ-031 On rst_i: FSM = DMA_PRIO, stall counters = 0, tracker valid bits = 0, so all rvalid_o = 0 and rdata_o = 0.
REQ-032 Reset mid-operation discards in-flight responses; no rvalid follows reset deassertion until a new handshake.
REQ-033 Combinational outputs (gnt, mem_*) follow inputs during reset with FSM in DMA_PRIO.

Structure
REQ-034 Package superbank_pkg holds arb_src_e {SRC_DMA, SRC_CORE} and state enum arb_state_e {DMA_PRIO, CORE_PRIO}.
REQ-035 Sub-module superbank_arb_slice implements one superbank (FSM, counter, tracker); top instantiates NrSuperBanks in a generate loop.

Verification (NrSuperBanks=4, MemoryLatency=1, MaxDmaStall=4)
REQ-036 Only DMA read on s=2, add=0x3F, mem_gnt_i=1 -> dma_gnt_o[2]=1 same cycle, mem_add_o[2]=0x3F, dma_rvalid_o[2]=1 next cycle with mem_rdata_i[2].
REQ-037 DMA and core request s=0 continuously, mem_gnt_i=1 -> DMA granted 4 cycles, core granted cycle 5, DMA cycle 6.
REQ-038 Core request in CORE_PRIO, mem_gnt_i=0 for 3 cycles -> state holds, neither granted; core granted when mem_gnt_i=1.
REQ-039 Alternate DMA/core handshakes every cycle on s=1 -> rvalid alternates dma/core, each one cycle after its handshake, never both.
REQ-040 Assert rst_i one cycle after handshake -> no rvalid_o follows; FSM in DMA_PRIO, counter 0.
REQ-041 MemoryLatency=3 variant: handshake at cycle t -> rvalid at t+3 with correct src.
